// File: rtl/mul_div_seq.sv
// Sequential unsigned multiply/divide unit with a single shared accumulator.
// Shift-add multiply and restoring divide, one bit per cycle, fixed latency.
module mul_div_seq #(
    parameter int WIDTH = 16,
    parameter int DST_W = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [DST_W-1:0] dst,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [DST_W-1:0] wr_dst,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [DST_W-1:0]   r_dst;
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_last;

    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial  = w_rem_sh - {1'b0, r_b};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign wr_en    = done;

    // Multiply keeps the adder carry by shifting the WIDTH+1-bit sum in.
    always_comb begin
        w_acc_nxt = r_acc;
        if (!r_op) begin
            if (r_acc[0])
                w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
            else
                w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
        end else begin
            if (!w_trial[WIDTH])
                w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_acc_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_dst       <= '0;
            r_acc       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_dst      <= '0;
            res_lo      <= '0;
            res_hi      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                // The DONE cycle doubles as the return to IDLE, so a start
                // seen there is accepted: one operation per WIDTH+1 cycles.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_dst   <= dst;
                        r_acc   <= {{WIDTH{1'b0}}, (op ? a : b)};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        res_lo      <= w_acc_nxt[WIDTH-1:0];
                        res_hi      <= w_acc_nxt[2*WIDTH-1:WIDTH];
                        div_by_zero <= r_op && (r_b == '0);
                        wr_dst      <= r_dst;
                        done        <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Randomized self-checking bench for mul_div_seq.
// Expected results come from plain integer arithmetic.
module tb_mul_div_seq;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dst;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [2:0]  wr_dst;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic        div_by_zero;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] last_lo  = '0;
    logic [15:0] last_hi  = '0;
    logic [2:0]  last_dst = '0;
    logic        last_dz  = 1'b0;

    always #5 clk = ~clk;

    mul_div_seq #(.WIDTH(16), .DST_W(3)) dut (
        .clk(clk),
        .rst_b(rst_b),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .dst(dst),
        .busy(busy),
        .done(done),
        .wr_en(wr_en),
        .wr_dst(wr_dst),
        .res_lo(res_lo),
        .res_hi(res_hi),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi, lo}: product, or {remainder, quotient}
    function automatic logic [31:0] model(input logic o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        logic [31:0] r;
        if (!o)
            r = 32'(x) * 32'(y);
        else if (y == 16'd0)
            r = {x, 16'hFFFF};
        else
            r = {16'(x % y), 16'(x / y)};
        return r;
    endfunction

    task automatic scramble();
        a   = 16'($urandom);
        b   = 16'($urandom);
        op  = 1'($urandom);
        dst = 3'($urandom);
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_res"}, {res_hi, res_lo}, {last_hi, last_lo});
        chk({tag, "_dst"}, {29'd0, wr_dst}, {29'd0, last_dst});
        chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, last_dz});
    endtask

    task automatic do_op(input logic o, input logic [15:0] x,
                         input logic [15:0] y, input logic [2:0] d);
        logic [31:0] e;
        e     = model(o, x, y);
        op    = o;
        a     = x;
        b     = y;
        dst   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        chk("busy_acc", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k < 16) begin
                chk("done_early", {31'd0, done}, 32'd0);
                chk_hold("run_hold");
            end
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("wr_en", {31'd0, wr_en}, 32'd1);
        chk("busy_done", {31'd0, busy}, 32'd1);
        chk("result", {res_hi, res_lo}, e);
        chk("wr_dst", {29'd0, wr_dst}, {29'd0, d});
        chk("dbz", {31'd0, div_by_zero}, {31'd0, (o && y == 16'd0)});
        last_hi  = e[31:16];
        last_lo  = e[15:0];
        last_dst = d;
        last_dz  = o && (y == 16'd0);
        @(posedge clk);
        #1;
        chk("done_after", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk_hold("post_hold");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {29'd0, busy, done, wr_en}, 32'd0);
        chk({tag, "_res"}, {res_hi, res_lo}, 32'd0);
        chk({tag, "_dst"}, {28'd0, wr_dst, div_by_zero}, 32'd0);
    endtask

    logic [15:0] ha [51];
    logic [15:0] hb [51];
    logic        ho [51];
    logic [2:0]  hd [51];

    initial begin
        rst_b = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        dst   = '0;
        #3;
        rst_b = 1'b0;
        #1;
        chk_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i % 5 == 4)
                chk("idle", {30'd0, busy, done}, 32'd0);
        end

        do_op(1'b0, 16'h1234, 16'h5678, 3'd5);
        do_op(1'b0, 16'hFFFF, 16'hFFFF, 3'd1);
        do_op(1'b0, 16'h0000, 16'hABCD, 3'd2);
        do_op(1'b1, 16'd1000, 16'd7, 3'd3);
        do_op(1'b1, 16'd5, 16'd9, 3'd4);
        do_op(1'b1, 16'h00AB, 16'h0000, 3'd6);
        do_op(1'b0, 16'h8000, 16'h0002, 3'd7);
        do_op(1'b1, 16'hFFFF, 16'h0001, 3'd0);

        for (int i = 0; i < 30; i++) begin
            logic [15:0] y;
            y = 16'($urandom);
            if (i % 7 == 3) y = 16'd0;
            if (i % 5 == 1) y = 16'($urandom_range(1, 15));
            do_op(1'($urandom), 16'($urandom), y, 3'($urandom));
        end

        // Reset in the middle of a multiply
        op    = 1'b0;
        a     = 16'h4321;
        b     = 16'h00F0;
        dst   = 3'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        chk_zero("reset_mid");
        #1;
        rst_b    = 1'b1;
        last_hi  = '0;
        last_lo  = '0;
        last_dst = '0;
        last_dz  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_rst", {30'd0, busy, done}, 32'd0);
        end
        do_op(1'b0, 16'h4321, 16'h00F0, 3'd2);

        // start held high with operands changing every cycle
        for (int e = 0; e <= 50; e++) begin
            if (e <= 34) begin
                start = 1'b1;
                scramble();
            end else begin
                start = 1'b0;
            end
            ha[e] = a;
            hb[e] = b;
            ho[e] = op;
            hd[e] = dst;
            @(posedge clk);
            #1;
            if (e == 16 || e == 33 || e == 50) begin
                int s;
                logic [31:0] x;
                s = (e == 16) ? 0 : ((e == 33) ? 17 : 34);
                x = model(ho[s], ha[s], hb[s]);
                chk("held_done", {31'd0, done}, 32'd1);
                chk("held_res", {res_hi, res_lo}, x);
                chk("held_dst", {29'd0, wr_dst}, {29'd0, hd[s]});
                chk("held_dz", {31'd0, div_by_zero},
                    {31'd0, (ho[s] && hb[s] == 16'd0)});
                last_hi  = x[31:16];
                last_lo  = x[15:0];
                last_dst = hd[s];
                last_dz  = ho[s] && (hb[s] == 16'd0);
            end else begin
                chk("held_nodone", {31'd0, done}, 32'd0);
                chk_hold("held_hold");
                if (e >= 1)
                    chk("held_busy", {31'd0, busy}, 32'd1);
            end
        end
        @(posedge clk);
        #1;
        chk("held_idle", {30'd0, busy, done}, 32'd0);
        chk_hold("held_final");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
